// File: rtl/cpu_defines.sv
// Shared CPU definitions: hazard FSM states, bypass selects, divider latency.
package cpu_defines;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    DIV_BUSY = 2'd1,
    EXC_PEND = 2'd2
  } hz_state_e;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  localparam int unsigned DIV_LAT_DEF = 34;

  // A producer hits a consumer index when it writes a non-zero register equal to it.
  function automatic logic reg_hit(input logic en, input logic [4:0] dst, input logic [4:0] src);
    return en && (dst != 5'd0) && (dst == src);
  endfunction

endpackage

// File: rtl/fwd_unit.sv
// Combinational bypass selection for the D and E stages.
module fwd_unit
  import cpu_defines::*;
(
  input  logic [4:0] rsD,
  input  logic [4:0] rtD,
  input  logic [4:0] rsE,
  input  logic [4:0] rtE,
  input  logic [4:0] writeregM,
  input  logic [4:0] writeregW,
  input  logic       regwriteM,
  input  logic       regwriteW,
  output logic       forwardAD,
  output logic       forwardBD,
  output logic [1:0] forwardAE,
  output logic [1:0] forwardBE
);

  // M has priority over W for E operands; D operands only bypass from M.
  always_comb begin
    forwardAE = FWD_RF;
    forwardBE = FWD_RF;
    if (reg_hit(regwriteM, writeregM, rsE))      forwardAE = FWD_M;
    else if (reg_hit(regwriteW, writeregW, rsE)) forwardAE = FWD_W;
    if (reg_hit(regwriteM, writeregM, rtE))      forwardBE = FWD_M;
    else if (reg_hit(regwriteW, writeregW, rtE)) forwardBE = FWD_W;
    forwardAD = reg_hit(regwriteM, writeregM, rsD);
    forwardBD = reg_hit(regwriteM, writeregM, rtD);
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stall/flush generation, divider occupancy FSM,
// exception recovery and front-end stall-cycle counting.
module hazard_ctrl
  import cpu_defines::*;
#(
  parameter int unsigned DIV_LAT = DIV_LAT_DEF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        i_stall,
  input  logic        d_stall,
  input  logic [4:0]  rsD,
  input  logic [4:0]  rtD,
  input  logic [4:0]  rsE,
  input  logic [4:0]  rtE,
  input  logic [4:0]  writeregE,
  input  logic [4:0]  writeregM,
  input  logic        regwriteE,
  input  logic        regwriteM,
  input  logic        memtoregE,
  input  logic        memtoregM,
  input  logic        branchD,
  input  logic        divE,
  input  logic        exceptM,
  output logic        stallF,
  output logic        stallD,
  output logic        stallE,
  output logic        stallM,
  output logic        stallW,
  output logic        flushD,
  output logic        flushE,
  output logic        flushM,
  output logic        flushW,
  output logic        forwardAD,
  output logic        forwardBD,
  output logic [1:0]  forwardAE,
  output logic [1:0]  forwardBE,
  output logic        div_busy,
  output logic [31:0] stall_cnt
);

  localparam logic [5:0] DIV_LOAD = 6'(DIV_LAT - 1);

  hz_state_e   state, state_nx;
  logic [5:0]  cnt, cnt_nx;
  logic        done, done_nx;
  logic [31:0] stall_cnt_q;
  logic [4:0]  writeregW;
  logic        regwriteW;
  logic        lu_haz, br_haz, e_hold;
  logic        s_f, s_d, s_e, s_m, s_w, f_d, f_e, f_m, f_w;
  logic        fad, fbd;
  logic [1:0]  fae, fbe;

  // Hazard detection: load-use and branch operand dependencies.
  always_comb begin
    lu_haz = memtoregE && (writeregE != 5'd0) && ((writeregE == rsD) || (writeregE == rtD));
    br_haz = branchD &&
             (reg_hit(regwriteE, writeregE, rsD) || reg_hit(regwriteE, writeregE, rtD) ||
              (memtoregM && ((writeregM == rsD) || (writeregM == rtD))));
  end

  // Raw stall/flush requests, highest priority first: exception, dcache miss, divider, hazards.
  always_comb begin
    s_f = 1'b0; s_d = 1'b0; s_e = 1'b0; s_m = 1'b0; s_w = 1'b0;
    f_d = 1'b0; f_e = 1'b0; f_m = 1'b0; f_w = 1'b0;
    if (exceptM) begin
      f_d = 1'b1; f_e = 1'b1; f_m = 1'b1;
    end else begin
      if (state == EXC_PEND) f_d = 1'b1;
      if (d_stall) begin
        s_f = 1'b1; s_d = 1'b1; s_e = 1'b1; s_m = 1'b1; s_w = 1'b1; f_w = 1'b1;
      end else if (state == DIV_BUSY) begin
        s_f = 1'b1; s_d = 1'b1; s_e = 1'b1; f_m = 1'b1;
      end else if (lu_haz || br_haz) begin
        s_f = 1'b1; s_d = 1'b1; f_e = 1'b1;
      end
      // An icache miss only bubbles D when D is not already being held.
      if (i_stall) begin
        s_f = 1'b1;
        if (!s_d) f_d = 1'b1;
      end
    end
    e_hold = s_e && !f_e;
  end

  // Next state, divider countdown and per-instruction done flag.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    done_nx  = done;
    if (!e_hold) done_nx = 1'b0;
    case (state)
      RUN: begin
        if (divE && !done && !exceptM && !d_stall) begin
          state_nx = DIV_BUSY;
          cnt_nx   = DIV_LOAD;
        end
      end
      DIV_BUSY: begin
        if (!d_stall) begin
          if (cnt == 6'd0) begin
            state_nx = RUN;
            done_nx  = 1'b1;
          end else begin
            cnt_nx = cnt - 6'd1;
          end
        end
      end
      EXC_PEND: begin
        if (!i_stall) state_nx = RUN;
      end
      default: state_nx = RUN;
    endcase
    if (exceptM) begin
      state_nx = i_stall ? EXC_PEND : RUN;
      cnt_nx   = '0;
      done_nx  = 1'b0;
    end
  end

  // State, divider counter and done flag registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= RUN;
      cnt   <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      done  <= done_nx;
    end
  end

  // Front-end stall-cycle counter, wraps naturally.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)  stall_cnt_q <= '0;
    else if (s_f) stall_cnt_q <= stall_cnt_q + 32'd1;
  end

  // W-stage destination is not a port: shadow M into W using our own flushW
  // (stallW can never take effect since W is flushed whenever it would stall).
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      writeregW <= '0;
      regwriteW <= 1'b0;
    end else if (f_w) begin
      writeregW <= '0;
      regwriteW <= 1'b0;
    end else begin
      writeregW <= writeregM;
      regwriteW <= regwriteM;
    end
  end

  fwd_unit u_fwd (
    .rsD       (rsD),
    .rtD       (rtD),
    .rsE       (rsE),
    .rtE       (rtE),
    .writeregM (writeregM),
    .writeregW (writeregW),
    .regwriteM (regwriteM),
    .regwriteW (regwriteW),
    .forwardAD (fad),
    .forwardBD (fbd),
    .forwardAE (fae),
    .forwardBE (fbe)
  );

  // Output gating: flush wins over stall, everything quiet while in reset.
  always_comb begin
    stallF    = resetn && s_f;
    stallD    = resetn && s_d && !f_d;
    stallE    = resetn && s_e && !f_e;
    stallM    = resetn && s_m && !f_m;
    stallW    = resetn && s_w && !f_w;
    flushD    = resetn && f_d;
    flushE    = resetn && f_e;
    flushM    = resetn && f_m;
    flushW    = resetn && f_w;
    forwardAD = resetn && fad;
    forwardBD = resetn && fbd;
    forwardAE = resetn ? fae : '0;
    forwardBE = resetn ? fbe : '0;
    div_busy  = (state == DIV_BUSY);
    stall_cnt = stall_cnt_q;
  end

endmodule
